// File: rtl/rgb_arbiter.sv
// Round-robin arbiter sharing one active-low RGB LED among N_REQ requesters (show, blank, repeat).
// Optional PWM brightness control is enabled by defining RGB_ARBITER_DIM_EN.
module rgb_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DWELL = 12000000,
    parameter int unsigned GAP   = 1200000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] color,
`ifdef RGB_ARBITER_DIM_EN
    input  logic [7:0]         bright,
`endif
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic               RGB_R,
    output logic               RGB_G,
    output logic               RGB_B
);

    localparam int unsigned MaxCnt = (DWELL > GAP) ? ((DWELL > 2) ? DWELL : 2)
                                                   : ((GAP > 2) ? GAP : 2);
    localparam int unsigned CntW = $clog2(MaxCnt);
    localparam int unsigned PtrW = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

    state_e           r_state, w_state_next;
    logic [CntW-1:0]  r_cnt, w_cnt_next;
    logic [PtrW-1:0]  r_ptr, w_ptr_next;
    logic [PtrW-1:0]  r_idx, w_idx_next;
    logic [2:0]       r_color, w_color_next;
    logic [N_REQ-1:0] r_grant, w_grant_next;
    logic [N_REQ-1:0] r_done, w_done_next;

    logic             w_any;
    logic [PtrW-1:0]  w_win;
    logic [PtrW:0]    w_j;
    logic             w_on;

    // First requesting index at or after r_ptr, wrapping around.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_j   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_j = {1'b0, r_ptr} + (PtrW+1)'(k);
            if (w_j >= (PtrW+1)'(N_REQ)) begin
                w_j = w_j - (PtrW+1)'(N_REQ);
            end
            if (!w_any && req[w_j[PtrW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_j[PtrW-1:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ptr_next   = r_ptr;
        w_idx_next   = r_idx;
        w_color_next = r_color;
        w_grant_next = r_grant;
        w_done_next  = '0;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_next = StShow;
                    w_cnt_next   = '0;
                    w_idx_next   = w_win;
                    w_color_next = color[3*w_win +: 3];
                    w_grant_next = N_REQ'(1) << w_win;
                end
            end
            StShow: begin
                if (r_cnt == CntW'(DWELL - 1)) begin
                    w_done_next[r_idx] = 1'b1;
                    w_grant_next       = '0;
                    w_cnt_next         = '0;
                    w_ptr_next         = (r_idx == PtrW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
                    w_state_next       = (GAP == 0) ? StIdle : StBlank;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StBlank: begin
                if (r_cnt == CntW'(GAP - 1)) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_color <= '0;
            r_grant <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ptr   <= w_ptr_next;
            r_idx   <= w_idx_next;
            r_color <= w_color_next;
            r_grant <= w_grant_next;
            r_done  <= w_done_next;
        end
    end

`ifdef RGB_ARBITER_DIM_EN
    logic [7:0] r_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 8'd1;
        end
    end

    assign w_on = (r_state == StShow) && (r_pwm < bright);
`else
    assign w_on = (r_state == StShow);
`endif

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = (r_state != StIdle);
    assign RGB_R = ~(w_on & r_color[2]);
    assign RGB_G = ~(w_on & r_color[1]);
    assign RGB_B = ~(w_on & r_color[0]);

endmodule

// File: tb/tb_rgb_arbiter.sv
// Scoreboard bench for rgb_arbiter: expected slots are queued with the stimulus and checked
// by a negedge monitor; a second instance with GAP=0 covers back-to-back slots.
module tb_rgb_arbiter;

    localparam int unsigned NReq  = 4;
    localparam int unsigned Dwell = 8;

    typedef struct {
        int         idx;
        logic [2:0] col;
        int         gap;
    } slot_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NReq-1:0] req, req0;
    logic [3*NReq-1:0] color;
    logic [NReq-1:0] grant, done, grant0, done0;
    logic            busy, busy0;
    logic            rgb_r, rgb_g, rgb_b, rgb_r0, rgb_g0, rgb_b0;

    int n_cmp = 0;
    int n_err = 0;
    int n_grants = 0;

    slot_t exp_q[$];

    always #5 clk = ~clk;

    rgb_arbiter #(.N_REQ(NReq), .DWELL(Dwell), .GAP(2)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .color (color),
`ifdef RGB_ARBITER_DIM_EN
        .bright(8'hFF),
`endif
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .RGB_R (rgb_r),
        .RGB_G (rgb_g),
        .RGB_B (rgb_b)
    );

    rgb_arbiter #(.N_REQ(NReq), .DWELL(Dwell), .GAP(0)) u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .req   (req0),
        .color (color),
`ifdef RGB_ARBITER_DIM_EN
        .bright(8'hFF),
`endif
        .grant (grant0),
        .done  (done0),
        .busy  (busy0),
        .RGB_R (rgb_r0),
        .RGB_G (rgb_g0),
        .RGB_B (rgb_b0)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Monitor: tracks each grant slot against the next queued expectation.
    slot_t      cur;
    int         in_slot = 0, len = 0, gap_cnt = 0, had_slot = 0;
    logic [3:0] exp_done;
    logic [2:0] exp_rgb;

    always @(negedge clk) begin
        if (rst) begin
            in_slot  = 0;
            had_slot = 0;
            gap_cnt  = 0;
        end else begin
            exp_done = '0;
            if (in_slot != 0) begin
                if (grant != '0) begin
                    len++;
                    exp_rgb = ~cur.col;
                    chk_eq("grant_hold", grant, 32'(1) << cur.idx);
                    chk_eq("rgb_show", {rgb_r, rgb_g, rgb_b}, exp_rgb);
                    chk_eq("busy_show", busy, 1);
                end else begin
                    chk_eq("dwell_len", len, Dwell);
                    chk_eq("rgb_end", {rgb_r, rgb_g, rgb_b}, 3'b111);
                    exp_done = 4'(1 << cur.idx);
                    in_slot  = 0;
                    had_slot = 1;
                    gap_cnt  = 1;
                end
            end else if (grant != '0) begin
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_grant", grant, 0);
                end else begin
                    cur = exp_q.pop_front();
                    exp_rgb = ~cur.col;
                    chk_eq("winner", grant, 32'(1) << cur.idx);
                    chk_eq("rgb_first", {rgb_r, rgb_g, rgb_b}, exp_rgb);
                    if (had_slot != 0 && cur.gap >= 0) chk_eq("gap_len", gap_cnt, cur.gap);
                    in_slot = 1;
                    len     = 1;
                    n_grants++;
                end
            end else begin
                gap_cnt++;
                chk_eq("rgb_idle", {rgb_r, rgb_g, rgb_b}, 3'b111);
            end
            chk_eq("done", done, exp_done);
        end
    end

    task automatic push_slot(input int idx, input logic [2:0] col);
        slot_t s;
        s.idx = idx;
        s.col = col;
        s.gap = 3;
        exp_q.push_back(s);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n = 0;
        while (n_grants < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_grants < target) chk_eq("wait_timeout", n_grants, target);
    endtask

    task automatic settle_and_drain(input string tag);
        repeat (20) @(negedge clk);
        chk_eq(tag, exp_q.size(), 0);
    endtask

    int base;
    logic [3:0] eg, ed;

    initial begin
        rst   = 1'b1;
        req   = '0;
        req0  = '0;
        color = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_grant", grant, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_rgb", {rgb_r, rgb_g, rgb_b}, 3'b111);
        @(negedge clk); #2;
        rst = 1'b0;

        // Single requester, red, held for a re-grant.
        do_reset();
        color = {9'b0, 3'b100};
        push_slot(0, 3'b100);
        push_slot(0, 3'b100);
        base = n_grants;
        @(negedge clk); #2;
        req = 4'b0001;
        @(posedge clk); #1;
        chk_eq("latency_grant", grant, 4'b0001);
        chk_eq("latency_rgb", {rgb_r, rgb_g, rgb_b}, 3'b011);
        wait_grants(base + 2, 60);
        #2;
        req = '0;
        settle_and_drain("t1_drain");

        // All four requesting: strict round-robin.
        do_reset();
        color = {3'b110, 3'b001, 3'b010, 3'b100};
        push_slot(0, 3'b100);
        push_slot(1, 3'b010);
        push_slot(2, 3'b001);
        push_slot(3, 3'b110);
        push_slot(0, 3'b100);
        base = n_grants;
        @(negedge clk); #2;
        req = 4'b1111;
        wait_grants(base + 5, 120);
        #2;
        req = '0;
        settle_and_drain("t2_drain");
        chk_eq("t2_slots", n_grants - base, 5);

        // Request drop and colour change mid-dwell do not affect the slot.
        do_reset();
        color = {9'b0, 3'b010};
        push_slot(0, 3'b010);
        base = n_grants;
        @(negedge clk); #2;
        req = 4'b0001;
        wait_grants(base + 1, 10);
        repeat (2) @(negedge clk);
        #2;
        req   = '0;
        color = {9'b0, 3'b111};
        settle_and_drain("t3_drain");
        chk_eq("t3_slots", n_grants - base, 1);

        // Asynchronous reset mid-show, then restart from requester 0.
        do_reset();
        color = {9'b0, 3'b001};
        push_slot(0, 3'b001);
        base = n_grants;
        @(negedge clk); #2;
        req = 4'b0001;
        wait_grants(base + 1, 10);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("arst_grant", grant, 0);
        chk_eq("arst_rgb", {rgb_r, rgb_g, rgb_b}, 3'b111);
        chk_eq("arst_busy", busy, 0);
        chk_eq("arst_done", done, 0);
        @(negedge clk); #2;
        color = {3'b110, 3'b001, 3'b010, 3'b100};
        push_slot(0, 3'b100);
        push_slot(1, 3'b010);
        base  = n_grants;
        req   = 4'b1111;
        rst   = 1'b0;
        wait_grants(base + 2, 60);
        #2;
        req = '0;
        settle_and_drain("t4_drain");

        // GAP=0 instance: slots separated by the single arbitration cycle.
        do_reset();
        color = {3'b110, 3'b001, 3'b010, 3'b100};
        @(negedge clk); #2;
        req0 = 4'b0011;
        for (int c = 0; c < 19; c++) begin
            @(posedge clk); #1;
            if (c < 8)        eg = 4'b0001;
            else if (c == 8)  eg = 4'b0000;
            else if (c < 17)  eg = 4'b0010;
            else if (c == 17) eg = 4'b0000;
            else              eg = 4'b0001;
            ed = (c == 8) ? 4'b0001 : (c == 17) ? 4'b0010 : 4'b0000;
            chk_eq("gap0_grant", grant0, eg);
            chk_eq("gap0_done", done0, ed);
        end
        req0 = '0;
        repeat (12) @(negedge clk);
        chk_eq("gap0_idle_busy", busy0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_arbiter.md
RGB_ARBITER -- requirements
Module: rgb_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the RGB LED (2..8).
REQ-002 Parameter DWELL, default 12000000: clock cycles a granted colour is shown (1 s at 12 MHz), >=1.
REQ-003 Parameter GAP, default 1200000: blank cycles between consecutive grants, >=0.
REQ-004 clk  input  1  12 MHz system clock.
REQ-005 rst  input  1  reset; one clock; asynchronous, active-high.
REQ-006 req  input  N_REQ  per-requester request level, bit i = requester i.
REQ-007 color  input  3*N_REQ  per-requester colour {R,G,B}, active-high, requester i at bits [3i+2:3i].
REQ-008 grant  output  N_REQ  one-hot, registered; bit i high while requester i's colour is shown.
REQ-009 done  output  N_REQ  one-cycle pulse on bit i when requester i's dwell completes.
REQ-010 busy  output  1  high in SHOW or BLANK state.
REQ-011 RGB_R, RGB_G, RGB_B  output  1 each  LED drives, active-low (1 = off).

Function
REQ-012 FSM states IDLE, SHOW, BLANK; one counter of width $clog2(max(DWELL,GAP,2)) shared by SHOW and BLANK.
REQ-013 IDLE: with req==0, stay in IDLE; all grant bits 0; RGB outputs all 1.
REQ-014 IDLE with any req bit set: pick winner round-robin starting at index ptr, wrapping N_REQ-1 -> 0; next cycle: state SHOW, grant one-hot on winner, counter 0.
REQ-015 Arbitration latency: req sampled high in IDLE at edge t -> grant and RGB valid after edge t+1.
REQ-016 On entry to SHOW, latch the winner's colour; RGB_x = ~latched_x for the whole dwell; later changes to color inputs are ignored.
REQ-017 SHOW lasts exactly DWELL cycles; req deasserted mid-dwell does not shorten it.
REQ-018 Last SHOW cycle (counter == DWELL-1): next cycle done[winner]=1 for one cycle, grant=0, RGB all 1, ptr = winner+1 mod N_REQ.
REQ-019 After SHOW: if GAP>0 enter BLANK for exactly GAP cycles, then IDLE; if GAP==0 go directly to IDLE.
REQ-020 BLANK: grant=0, RGB all 1, busy=1; requests are not sampled.
REQ-021 A requester holding req continuously is re-granted only after every other pending requester has been served once (no starvation).
REQ-022 Simultaneous requests in IDLE: only the round-robin winner is granted; others remain pending, with no loss.
REQ-023 At most one grant bit high in any cycle; done never coincides with grant on the same bit.

Reset
REQ-024 rst high asynchronously forces: state IDLE, counter 0, ptr 0, latched colour 0, grant 0, done 0, busy 0, RGB_R/G/B = 1.
REQ-025 Reset mid-SHOW aborts the slot immediately, with no done pulse; after release, arbitration restarts from requester 0.

Configuration
REQ-026 Macro RGB_ARBITER_DIM_EN defined: add input port bright (8 bits) and a free-running 8-bit PWM counter reset to 0; during SHOW a latched colour bit drives its LED low only when pwm_cnt < bright; bright=0 gives fully off, bright=255 gives 255/256 duty.
REQ-027 Macro RGB_ARBITER_DIM_EN undefined: no bright port, no PWM counter; latched colour drives the LEDs at full duty.

Verification (DWELL=8, GAP=2, N_REQ=4)
REQ-028 req=4'b0001, colour0=3'b100 -> grant=0001 one cycle after req; RGB={0,1,1} for 8 cycles; done[0] pulse; 2 blank cycles; re-grant.
REQ-029 req=4'b1111 held -> grant order 0,1,2,3,0, each 8 cycles, with 2-cycle blanks between; exactly one done pulse per slot.
REQ-030 req0 dropped after 3 SHOW cycles, colour0 changed mid-dwell -> dwell still 8 cycles with the original colour; done[0] pulses.
REQ-031 rst asserted at SHOW cycle 4 -> grant=0 and RGB=111 without a clock edge; no done; after release with req=1111, requester 0 is granted first.
REQ-032 GAP=0, req=0011 -> grant 0 then grant 1 with only the one-cycle IDLE arbitration cycle between slots.
REQ-033 DIM_EN, bright=64, colour=3'b001 -> RGB_B low for 64 of every 256 SHOW cycles (run with DWELL>=256); RGB_R and RGB_G stay 1.
